// File: rtl/clint_timer_if.sv
// Bus bundle between the load/store arbiter and the CLINT timer.
// One request per cycle, fixed one-cycle response, no backpressure.
interface clint_timer_if;
    logic [31:0] addr_i;
    logic        valid_i;
    logic        write_valid_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        addr_err_o;

    modport master (
        output addr_i, valid_i, write_valid_i, wdata_i,
        input  rdata_o, ready_o, addr_err_o
    );

    modport slave (
        input  addr_i, valid_i, write_valid_i, wdata_i,
        output rdata_o, ready_o, addr_err_o
    );
endinterface

// File: rtl/clint_timer.sv
// Machine timer (mtime/mtimecmp) and software interrupt (msip) for the trap unit,
// exposed as 32-bit halves with a hi shadow for tear-free 64-bit reads.
module clint_timer #(
    parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
    parameter int          PRESCALE     = 1,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic          clk,
    input  logic          rst,
    clint_timer_if.slave  bus,
    output logic          timer_irq_o,
    output logic          soft_irq_o
);

    localparam int              PSC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

    logic [63:0]      mtime;
    logic [63:0]      mtimecmp;
    logic             msip;
    logic [PSC_W-1:0] psc;
    logic [31:0]      hi_shadow;
    logic             shadow_vld;

    logic [15:0] offset;
    logic        base_hit;
    logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic        mapped, rd, wr, tick, time_wr;
    logic [31:0] rd_value;

    assign offset      = bus.addr_i[15:0];
    assign base_hit    = (bus.addr_i[31:16] == BASE_ADDR[31:16]);
    assign sel_msip    = base_hit && (offset == 16'h0000);
    assign sel_cmp_lo  = base_hit && (offset == 16'h4000);
    assign sel_cmp_hi  = base_hit && (offset == 16'h4004);
    assign sel_time_lo = base_hit && (offset == 16'hBFF8);
    assign sel_time_hi = base_hit && (offset == 16'hBFFC);
    assign mapped      = sel_msip || sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi;

    assign rd      = bus.valid_i && !bus.write_valid_i;
    assign wr      = bus.valid_i && bus.write_valid_i;
    assign tick    = (psc == PSC_MAX);
    assign time_wr = wr && (sel_time_lo || sel_time_hi);

    assign soft_irq_o = msip;

    // Read data comes from pre-edge state; a pending shadow overrides the live hi word.
    always_comb begin
        rd_value = '0;
        if (sel_msip)
            rd_value = {31'b0, msip};
        else if (sel_cmp_lo)
            rd_value = mtimecmp[31:0];
        else if (sel_cmp_hi)
            rd_value = mtimecmp[63:32];
        else if (sel_time_lo)
            rd_value = mtime[31:0];
        else if (sel_time_hi)
            rd_value = shadow_vld ? hi_shadow : mtime[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ready_o    <= 1'b0;
            bus.addr_err_o <= 1'b0;
            bus.rdata_o    <= '0;
            timer_irq_o    <= 1'b0;
        end else begin
            bus.ready_o    <= bus.valid_i;
            bus.addr_err_o <= bus.valid_i && !mapped;
            if (bus.valid_i)
                bus.rdata_o <= rd ? rd_value : 32'h0;
            timer_irq_o    <= (mtime >= mtimecmp);
        end
    end

    // A software write to either mtime half suppresses the whole 64-bit increment
    // and restarts the prescaler so the new value gets a full tick period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime      <= '0;
            mtimecmp   <= MTIMECMP_RST;
            msip       <= 1'b0;
            psc        <= '0;
            hi_shadow  <= '0;
            shadow_vld <= 1'b0;
        end else begin
            if (time_wr) begin
                if (sel_time_lo)
                    mtime[31:0] <= bus.wdata_i;
                else
                    mtime[63:32] <= bus.wdata_i;
                psc <= '0;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
                psc   <= '0;
            end else begin
                psc <= psc + 1'b1;
            end

            if (time_wr) begin
                shadow_vld <= 1'b0;
            end else if (rd && sel_time_lo) begin
                hi_shadow  <= mtime[63:32];
                shadow_vld <= 1'b1;
            end else if (rd && sel_time_hi) begin
                shadow_vld <= 1'b0;
            end

            if (wr && sel_cmp_lo)
                mtimecmp[31:0] <= bus.wdata_i;
            if (wr && sel_cmp_hi)
                mtimecmp[63:32] <= bus.wdata_i;
            if (wr && sel_msip)
                msip <= bus.wdata_i[0];
        end
    end

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer and software-interrupt source for the trap unit. Holds 64-bit `mtime`, 64-bit `mtimecmp` and `msip`, all accessed over a 32-bit bus in two halves. It drives the level signals that the trap unit's interrupt arbitration consumes: `timer_irq_o` (mtime ≥ mtimecmp) and `soft_irq_o`. It sits between the load/store arbiter and the trap/CSR control block.

## Interface
- `BASE_ADDR`, 32'h0200_0000: base of the 64 KiB CLINT window.
- `PRESCALE`, 1: clk cycles per mtime increment; legal range ≥1.
- `MTIMECMP_RST`, 64'hFFFF_FFFF_FFFF_FFFF: reset value of mtimecmp.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `addr_i` in 32: byte address. Only word-aligned offsets are decoded.
- `valid_i` in 1: access request, accepted every cycle it is high.
- `write_valid_i` in 1: qualifies `valid_i` as a write.
- `wdata_i` in 32: write data.
- `rdata_o` out 32: read data, valid while `ready_o` is high.
- `ready_o` out 1: response pulse for each accepted access.
- `addr_err_o` out 1: response pulse for an access outside the register map.
- `timer_irq_o` out 1: registered `mtime >= mtimecmp`.
- `soft_irq_o` out 1: `msip[0]`.

## Operation
- Offsets from `BASE_ADDR`:
  - 0x0000: msip. Only bit 0 is implemented; other bits read 0.
  - 0x4000 / 0x4004: mtimecmp lo / hi.
  - 0xBFF8 / 0xBFFC: mtime lo / hi.
- Address hit: `addr_i[31:16] == BASE_ADDR[31:16]` and the offset matches the table exactly. Any other address inside or outside the window is unmapped.
- Unmapped access:
  - reads return 0;
  - writes have no effect;
  - `addr_err_o` pulses together with `ready_o`.
- Prescaler:
  - `psc` counts 0..PRESCALE-1 and wraps to 0.
  - `tick = (psc == PRESCALE-1)`.
  - With PRESCALE=1, tick is high every cycle.
- mtime advances by 1 on tick and wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0. Arithmetic is unsigned 64-bit; there is no carry-out flag.
- Write to an mtime half:
  - the written half takes `wdata_i`;
  - the other half holds;
  - the increment is suppressed that cycle;
  - `psc` clears to 0.
- Write to a mtimecmp half replaces that half only.
- Write to msip: `msip <= wdata_i[0]`.
- Read coherency via a hi shadow, `hi_shadow` plus `shadow_vld`:
  - A read of mtime lo returns the current low word, captures the current high word into `hi_shadow`, and sets `shadow_vld`.
  - A read of mtime hi with `shadow_vld=1` returns `hi_shadow` and clears `shadow_vld`.
  - A read of mtime hi with `shadow_vld=0` returns the live high word.
  - Any write to mtime clears `shadow_vld`.
- Response pipeline is 1 stage:
  - Read data is decoded from register state at the request cycle, before that cycle's write or tick.
  - It is registered into `rdata_o`.
- Compare: `timer_irq_o <= (mtime >= mtimecmp)`, evaluated on the pre-edge register values. The output is level-sensitive. It clears only when software raises mtimecmp or lowers mtime.

## Timing
- Reset values:
  - mtime = 0, mtimecmp = `MTIMECMP_RST`, msip = 0;
  - `psc` = 0, `shadow_vld` = 0, `hi_shadow` = 0;
  - `rdata_o` = 0, `ready_o` = 0, `addr_err_o` = 0, `timer_irq_o` = 0, `soft_irq_o` = 0.
- Reset assertion mid-access drops any pending response. `ready_o` is 0 on the cycle after rst deasserts.
- Accepted access in cycle N:
  - `ready_o`, `rdata_o` and `addr_err_o` are valid in cycle N+1 for exactly one cycle.
  - A write's effect is visible to a read issued in N+1.
- Back-to-back accesses are accepted at one per cycle. There is no stall and no backpressure.
- Between responses, `rdata_o` holds its last read value. Write responses drive `rdata_o` = 0.
- `timer_irq_o` lags its register state by 1 cycle:
  - A mtimecmp write in N that satisfies the compare raises the output at N+2.
  - A write that breaks the compare drops the output at N+2.
- `soft_irq_o` follows an msip write one cycle later (N+1).
- Simultaneous mtime-hi write and tick: the write wins and lo holds, because the increment is suppressed for the whole 64 bits.

## Test plan
- **Reset.** Assert rst asynchronously mid-cycle -> all outputs 0 immediately. Then read 0xBFF8 -> 0 on the next `ready_o`, with PRESCALE=1 and the read issued in the first cycle after reset.
- **Prescale.** PRESCALE=4, idle for 40 cycles after reset, read mtime lo -> 10.
- **Rollover coherency.** Write mtime hi=0, then lo=0xFFFF_FFFE. Read lo, wait 5 cycles, read hi -> lo=0xFFFF_FFFE, hi=0 (shadow). A second hi read -> 1.
- **Compare.** With mtime=100, write mtimecmp hi=0, then lo=50 -> `timer_irq_o`=1 two cycles after the lo write. Write mtimecmp lo=0xFFFF_FFFF -> `timer_irq_o` drops two cycles later.
- **msip and unmapped access.** Write 0x0000=0xFFFF_FFFF -> `soft_irq_o`=1, and a read returns 1. Write 0x0004 -> `addr_err_o`=1 with `ready_o`, and msip is unchanged.
- **Full 64-bit wrap.** Write mtime=64'hFFFF_FFFF_FFFF_FFFF, wait 1 tick -> reads lo=0, hi=0. `timer_irq_o` follows the new compare result.
